// File: rtl/am_wave_gen_pkg.sv
// am_wave_gen_pkg: shared types and constants for the AM test-waveform
// generator and its sequential divide-by-constant.
//   state_t      calculation FSM states
//   MID_CODE     12-bit mid-scale code the carrier is centred on
//   DIV_CONST    divisor turning A*m (percent) into d
//   MAX_INDX     modulation index clamp, percent
//   PROD_W/QUOT_W  product and quotient widths
package am_wave_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_LOAD
  } state_t;

  localparam int unsigned MID_CODE  = 2048;
  localparam int unsigned DIV_CONST = 100;
  localparam int unsigned MAX_INDX  = 100;
  localparam int unsigned PROD_W    = 17;
  localparam int unsigned QUOT_W    = 10;
  localparam int unsigned AMP_W     = 10;
  localparam int unsigned INDX_W    = 8;
  localparam int unsigned M_W       = 7;
  localparam int unsigned ENV_W     = 11;
  localparam int unsigned WAVE_W    = 12;

  function automatic logic [M_W-1:0] clamp_indx(input logic [INDX_W-1:0] v);
    return (v > INDX_W'(MAX_INDX)) ? M_W'(MAX_INDX) : v[M_W-1:0];
  endfunction

endpackage

// File: rtl/am_wave_gen_if.sv
// am_wave_gen_if: request/response and waveform bundle of am_wave_gen.
//   pls, start, indx_set, amp            driven by the master
//   busy, cal_dn, gen_vld, env_hi,
//   env_lo, wave                          driven by the generator (slave)
//   pp_t2b, pp_b2t                        only with AM_WAVE_GEN_PP_OUT_EN
interface am_wave_gen_if;
  import am_wave_gen_pkg::*;

  logic                pls;
  logic                start;
  logic [INDX_W-1:0]   indx_set;
  logic [AMP_W-1:0]    amp;
  logic                busy;
  logic                cal_dn;
  logic                gen_vld;
  logic [ENV_W-1:0]    env_hi;
  logic [ENV_W-1:0]    env_lo;
  logic [WAVE_W-1:0]   wave;
`ifdef AM_WAVE_GEN_PP_OUT_EN
  logic [WAVE_W-1:0]   pp_t2b;
  logic [WAVE_W-1:0]   pp_b2t;
`endif

  modport master (
    output pls, start, indx_set, amp,
`ifdef AM_WAVE_GEN_PP_OUT_EN
    input  pp_t2b, pp_b2t,
`endif
    input  busy, cal_dn, gen_vld, env_hi, env_lo, wave
  );

  modport slave (
    input  pls, start, indx_set, amp,
`ifdef AM_WAVE_GEN_PP_OUT_EN
    output pp_t2b, pp_b2t,
`endif
    output busy, cal_dn, gen_vld, env_hi, env_lo, wave
  );

endinterface

// File: rtl/am_wave_div.sv
// am_wave_div: restoring shift-subtract divider by a constant, one quotient
// bit per clk, MSB first; PROD_W clks per division.
//   clk, rst   clock, synchronous active-high reset
//   start      load dividend and begin (restarts any division in flight)
//   dividend   PROD_W-bit unsigned dividend
//   done       high during the final step; quotient is valid the clk after
//   quotient   QUOT_W-bit quotient (caller guarantees it fits)
module am_wave_div
  import am_wave_gen_pkg::*;
#(
  parameter int unsigned DIVISOR = DIV_CONST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PROD_W-1:0] dividend,
  output logic              done,
  output logic [QUOT_W-1:0] quotient
);

  localparam int unsigned RW = $clog2(DIVISOR);
  localparam int unsigned TW = RW + 1;
  localparam int unsigned CW = $clog2(PROD_W);

  logic [PROD_W-1:0] dvd;
  logic [RW-1:0]     rem;
  logic [CW-1:0]     cnt;
  logic              run;
  logic [TW-1:0]     trial;
  logic              fits;

  always_comb begin
    trial = {rem, dvd[PROD_W-1]};
    fits  = (trial >= TW'(DIVISOR));
  end

  // Combinational so the caller can leave its DIV state on the last step.
  assign done = run && (cnt == CW'(PROD_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd      <= '0;
      rem      <= '0;
      cnt      <= '0;
      run      <= 1'b0;
      quotient <= '0;
    end else if (start) begin
      dvd      <= dividend;
      rem      <= '0;
      cnt      <= '0;
      run      <= 1'b1;
      quotient <= '0;
    end else if (run) begin
      rem      <= fits ? RW'(trial - TW'(DIVISOR)) : RW'(trial);
      quotient <= {quotient[QUOT_W-2:0], fits};
      dvd      <= {dvd[PROD_W-2:0], 1'b0};
      cnt      <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/am_wave_gen.sv
// am_wave_gen: AM test-waveform source. Computes envelope limits A+d / A-d
// with d = A*m/100 (sequential divide), then emits a square carrier around
// MID_CODE whose amplitude follows a triangle between those limits.
//   clk, rst   clock, synchronous active-high reset
//   bus        am_wave_gen_if.slave: pls, start, indx_set, amp in;
//              busy, cal_dn, gen_vld, env_hi, env_lo, wave out
// Optional: define AM_WAVE_GEN_PP_OUT_EN to add pp_t2b = 2*env_hi and
// pp_b2t = 2*env_lo on the interface for index-calculator loopback.
module am_wave_gen
  import am_wave_gen_pkg::*;
#(
  parameter int unsigned CAR_HALF = 8,
  parameter int unsigned ENV_DIV  = 4
) (
  input logic          clk,
  input logic          rst,
  am_wave_gen_if.slave bus
);

  localparam int unsigned CCW = $clog2(CAR_HALF + 1);
  localparam int unsigned ECW = $clog2(ENV_DIV + 1);

  state_t              state;
  logic [M_W-1:0]      m_lat;
  logic [AMP_W-1:0]    a_lat;
  logic [PROD_W-1:0]   product;
  logic                div_start;
  logic                div_done;
  logic [QUOT_W-1:0]   quot;
  logic [ENV_W-1:0]    new_hi;
  logic [ENV_W-1:0]    new_lo;
  logic                load_now;

  logic                busy_r;
  logic                cal_dn_r;
  logic                gen_vld_r;
  logic [ENV_W-1:0]    env_hi_r;
  logic [ENV_W-1:0]    env_lo_r;
  logic [WAVE_W-1:0]   wave_r;

  logic [CCW-1:0]      car_cnt;
  logic [ECW-1:0]      env_cnt;
  logic                car_wrap;
  logic                env_wrap;
  logic                phase;
  logic                dir_up;
  logic [ENV_W-1:0]    env;

  // The MUL cycle feeds the divider directly; its dividend register holds P.
  assign product   = PROD_W'(a_lat) * PROD_W'(m_lat);
  assign div_start = (state == ST_MUL);
  assign new_hi    = ENV_W'(a_lat) + ENV_W'(quot);
  assign new_lo    = ENV_W'(a_lat) - ENV_W'(quot);
  // A start arriving in LOAD aborts it, so the limits are not applied.
  assign load_now  = (state == ST_LOAD) && !bus.start;

  am_wave_div #(
    .DIVISOR (DIV_CONST)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (product),
    .done     (div_done),
    .quotient (quot)
  );

`ifdef AM_WAVE_GEN_PP_OUT_EN
  logic [WAVE_W-1:0] pp_t2b_r;
  logic [WAVE_W-1:0] pp_b2t_r;
  assign bus.pp_t2b = pp_t2b_r;
  assign bus.pp_b2t = pp_b2t_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      m_lat     <= '0;
      a_lat     <= '0;
      busy_r    <= 1'b0;
      cal_dn_r  <= 1'b0;
      gen_vld_r <= 1'b0;
      env_hi_r  <= '0;
      env_lo_r  <= '0;
`ifdef AM_WAVE_GEN_PP_OUT_EN
      pp_t2b_r  <= '0;
      pp_b2t_r  <= '0;
`endif
    end else begin
      cal_dn_r <= 1'b0;
      if (bus.start) begin
        m_lat  <= clamp_indx(bus.indx_set);
        a_lat  <= bus.amp;
        busy_r <= 1'b1;
        state  <= ST_MUL;
      end else begin
        case (state)
          ST_IDLE: state <= ST_IDLE;
          ST_MUL:  state <= ST_DIV;
          ST_DIV:  if (div_done) state <= ST_LOAD;
          ST_LOAD: begin
            env_hi_r  <= new_hi;
            env_lo_r  <= new_lo;
`ifdef AM_WAVE_GEN_PP_OUT_EN
            pp_t2b_r  <= {new_hi, 1'b0};
            pp_b2t_r  <= {new_lo, 1'b0};
`endif
            cal_dn_r  <= 1'b1;
            gen_vld_r <= 1'b1;
            busy_r    <= 1'b0;
            state     <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign car_wrap = (car_cnt == CCW'(CAR_HALF - 1));
  assign env_wrap = (env_cnt == ECW'(ENV_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      car_cnt <= '0;
      env_cnt <= '0;
      phase   <= 1'b0;
      dir_up  <= 1'b1;
      env     <= '0;
      wave_r  <= WAVE_W'(MID_CODE);
    end else begin
      if (!gen_vld_r)
        wave_r <= WAVE_W'(MID_CODE);
      else if (phase)
        wave_r <= WAVE_W'(MID_CODE) + {1'b0, env};
      else
        wave_r <= WAVE_W'(MID_CODE) - {1'b0, env};

      if (bus.pls) begin
        car_cnt <= car_wrap ? '0 : car_cnt + 1'b1;
        env_cnt <= env_wrap ? '0 : env_cnt + 1'b1;
        if (car_wrap) phase <= ~phase;
      end

      if (load_now) begin
        env    <= new_lo;
        dir_up <= 1'b1;
      end else if (bus.pls && env_wrap && (env_hi_r != env_lo_r)) begin
        // Turnaround is taken on the step after a limit is reached, so each
        // limit is held for one full envelope step like any other level.
        if (dir_up) begin
          if (env >= env_hi_r) begin
            dir_up <= 1'b0;
            env    <= env - 1'b1;
          end else begin
            env    <= env + 1'b1;
          end
        end else begin
          if (env <= env_lo_r) begin
            dir_up <= 1'b1;
            env    <= env + 1'b1;
          end else begin
            env    <= env - 1'b1;
          end
        end
      end
    end
  end

  assign bus.busy    = busy_r;
  assign bus.cal_dn  = cal_dn_r;
  assign bus.gen_vld = gen_vld_r;
  assign bus.env_hi  = env_hi_r;
  assign bus.env_lo  = env_lo_r;
  assign bus.wave    = wave_r;

endmodule

// File: tb/tb_am_wave_gen.sv
// tb_am_wave_gen: randomized scoreboard bench for am_wave_gen. A reference
// model predicts limits, latency and the waveform from the arithmetic rules
// (pls counts, closed-form triangle); a monitor compares every cycle.
module tb_am_wave_gen;

  localparam int unsigned TB_CAR = 1;
  localparam int unsigned TB_ENV = 2;
  localparam int unsigned LAT    = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;

  am_wave_gen_if bus ();

  am_wave_gen #(
    .CAR_HALF (TB_CAR),
    .ENV_DIV  (TB_ENV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) bus.pls = ($urandom_range(3) != 0);

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned at;
    logic [10:0] hi;
    logic [10:0] lo;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned npls = 0;
  int unsigned kst = 0;
  int unsigned load_edge = 0;
  int unsigned mm, dd, aa;
  logic [10:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          m_phase = 0, m_vld = 0, pend = 0, ld = 0;
  logic [11:0] exp_wave = 12'd2048;
  exp_t        ent;

  function automatic int unsigned tri_env(int unsigned lo, int unsigned hi, int unsigned k);
    int unsigned span, per, pos;
    span = hi - lo;
    if (span == 0) return lo;
    per = 2 * span;
    pos = k % per;
    return lo + ((pos <= span) ? pos : per - pos);
  endfunction

  always @(posedge clk) begin
    int unsigned e;
    cyc = cyc + 1;
    if (rst) begin
      npls = 0; kst = 0; m_hi = '0; m_lo = '0;
      m_phase = 0; m_vld = 0; pend = 0;
      q.delete();
      exp_wave = 12'd2048;
    end else begin
      e = tri_env(32'(m_lo), 32'(m_hi), kst);
      exp_wave = !m_vld ? 12'd2048 : (m_phase ? 12'(2048 + e) : 12'(2048 - e));
      ld = 0;
      if (bus.start) begin
        if (pend) void'(q.pop_back());
        mm = (32'(bus.indx_set) > 100) ? 100 : 32'(bus.indx_set);
        aa = 32'(bus.amp);
        dd = (aa * mm) / 100;
        p_hi = 11'(aa + dd);
        p_lo = 11'(aa - dd);
        load_edge = cyc + LAT;
        pend = 1;
        ent.at = load_edge; ent.hi = p_hi; ent.lo = p_lo;
        q.push_back(ent);
      end else if (pend && cyc == load_edge) begin
        m_hi = p_hi; m_lo = p_lo; m_vld = 1; kst = 0; pend = 0; ld = 1;
      end
      if (bus.pls) begin
        npls = npls + 1;
        if (npls % TB_CAR == 0) m_phase = !m_phase;
        if ((npls % TB_ENV == 0) && !ld) kst = kst + 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          win = 0, prev_win = 0;
  int unsigned ext_min = 0, ext_max = 0, wmin = 0, wmax = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("wave", 32'(bus.wave), 32'(exp_wave));
    chk("busy", 32'(bus.busy), 32'(pend));
    chk("gen_vld", 32'(bus.gen_vld), 32'(m_vld));
    chk("env_hi", 32'(bus.env_hi), 32'(m_hi));
    chk("env_lo", 32'(bus.env_lo), 32'(m_lo));
`ifdef AM_WAVE_GEN_PP_OUT_EN
    chk("pp_t2b", 32'(bus.pp_t2b), 32'(m_hi) * 2);
    chk("pp_b2t", 32'(bus.pp_b2t), 32'(m_lo) * 2);
`endif
    if (bus.cal_dn) begin
      if (q.size() != 0 && q[0].at == cyc) begin
        chk("cal_env_hi", 32'(bus.env_hi), 32'(q[0].hi));
        chk("cal_env_lo", 32'(bus.env_lo), 32'(q[0].lo));
        void'(q.pop_front());
      end else begin
        chk("cal_dn_unexpected", 32'(1), 32'(0));
      end
    end
    if (q.size() != 0 && q[0].at < cyc) begin
      chk("cal_dn_missing", 32'(0), 32'(1));
      void'(q.pop_front());
    end
    if (win && !prev_win) begin
      wmin = 4095; wmax = 0;
    end
    if (win) begin
      if (32'(bus.wave) < wmin) wmin = 32'(bus.wave);
      if (32'(bus.wave) > wmax) wmax = 32'(bus.wave);
    end
    if (!win && prev_win) begin
      chk("wave_min", wmin, ext_min);
      chk("wave_max", wmax, ext_max);
    end
    prev_win = win;
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input logic [9:0] a, input logic [7:0] i);
    @(negedge clk);
    bus.start = 1'b1;
    bus.amp = a;
    bus.indx_set = i;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic sweep(input int unsigned lo_exp, input int unsigned hi_exp, input int unsigned n);
    ext_min = lo_exp;
    ext_max = hi_exp;
    win = 1;
    repeat (n) @(negedge clk);
    win = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.amp = '0;
    bus.indx_set = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    do_start(10'd1000, 8'd50);
    repeat (25) @(negedge clk);
    sweep(548, 3548, 6000);

    do_start(10'd1000, 8'd33);
    repeat (30) @(negedge clk);

    do_start(10'd1023, 8'd200);
    repeat (25) @(negedge clk);
    sweep(2, 4094, 12000);

    do_start(10'd512, 8'd0);
    repeat (25) @(negedge clk);
    sweep(1536, 2560, 200);

    do_start(10'd700, 8'd40);
    repeat (3) @(negedge clk);
    do_start(10'd300, 8'd90);
    repeat (30) @(negedge clk);

    do_start(10'd900, 8'd70);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      do_start(10'($urandom_range(1023)), 8'($urandom_range(255)));
      repeat ($urandom_range(30)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
